// File: rtl/spell_stack_engine.sv
// rtl/spell_stack_engine.sv - operand stack with valid/ready ops, sticky errors and debug chain
module spell_stack_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   op_code,
  input  logic [DATA_W-1:0]            op_data,
  output logic                         done,
  output logic                         done_err,
  output logic [DATA_W-1:0]            top,
  output logic [DATA_W-1:0]            below,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_overflow,
  output logic                         err_underflow,
  input  logic                         err_clear,
  input  logic                         dbg_shift_in,
  output logic                         dbg_shift_out,
  input  logic                         dbg_load,
  input  logic                         dbg_dump
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, ROT2} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [CNT_W-1:0]    depth_q, depth_d;
  logic [DATA_W-1:0]   temp_q, temp_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                shout_q;
  logic                done_q, done_d;
  logic                done_err_q, done_err_d;
  logic                ovf_q, unf_q;
  logic                set_ovf, set_unf;
  logic                rdy_en_q;

  logic                wr0_en, wr1_en;
  logic [IDX_W-1:0]    wr0_idx, wr1_idx;
  logic [DATA_W-1:0]   wr0_data, wr1_data;

  logic [IDX_W-1:0]    idx_d, idx_m1, idx_m2, idx_m3;
  logic                full, accept;

  assign idx_d  = IDX_W'(depth_q);
  assign idx_m1 = IDX_W'(depth_q - CNT_W'(1));
  assign idx_m2 = IDX_W'(depth_q - CNT_W'(2));
  assign idx_m3 = IDX_W'(depth_q - CNT_W'(3));
  assign full   = (depth_q == CNT_W'(DEPTH));

  assign top   = (depth_q >= CNT_W'(1)) ? mem_q[idx_m1] : '0;
  assign below = (depth_q >= CNT_W'(2)) ? mem_q[idx_m2] : '0;

  // rdy_en_q holds op_ready low until the first edge after reset release
  assign op_ready = rdy_en_q & (state_q == IDLE) & !dbg_load & !dbg_dump;
  assign accept   = op_valid & op_ready;

  assign depth         = depth_q;
  assign done          = done_q;
  assign done_err      = done_err_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign dbg_shift_out = shout_q;

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    temp_d     = temp_q;
    shift_d    = {shift_q[DATA_W-2:0], dbg_shift_in};
    done_d     = 1'b0;
    done_err_d = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    wr0_en     = 1'b0;
    wr0_idx    = idx_m1;
    wr0_data   = '0;
    wr1_en     = 1'b0;
    wr1_idx    = idx_m2;
    wr1_data   = '0;

    case (state_q)
      IDLE: begin
        if (dbg_load) begin
          if (full) begin
            set_ovf = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_d;
            wr0_data = shift_q;
            depth_d  = depth_q + CNT_W'(1);
          end
        end else if (dbg_dump) begin
          shift_d = top;
        end

        if (accept) begin
          done_d = 1'b1;
          case (op_code)
            3'd1: begin
              if (full) begin
                set_ovf = 1'b1;
              end else begin
                wr0_en   = 1'b1;
                wr0_idx  = idx_d;
                wr0_data = op_data;
                depth_d  = depth_q + CNT_W'(1);
              end
            end
            3'd2: begin
              if (depth_q < CNT_W'(1)) set_unf = 1'b1;
              else depth_d = depth_q - CNT_W'(1);
            end
            3'd3: begin
              if (full) begin
                set_ovf = 1'b1;
              end else if (depth_q < CNT_W'(1)) begin
                set_unf = 1'b1;
              end else begin
                wr0_en   = 1'b1;
                wr0_idx  = idx_d;
                wr0_data = mem_q[idx_m1];
                depth_d  = depth_q + CNT_W'(1);
              end
            end
            3'd4: begin
              if (depth_q < CNT_W'(2)) begin
                set_unf = 1'b1;
              end else begin
                wr0_en   = 1'b1;
                wr0_data = mem_q[idx_m2];
                wr1_en   = 1'b1;
                wr1_data = mem_q[idx_m1];
              end
            end
            3'd5: begin
              if (depth_q < CNT_W'(3)) begin
                set_unf = 1'b1;
              end else begin
                // a b c -> b c a: top/below now, entry[d-3] on the ROT2 edge
                wr0_en   = 1'b1;
                wr0_data = mem_q[idx_m3];
                wr1_en   = 1'b1;
                wr1_data = mem_q[idx_m1];
                temp_d   = mem_q[idx_m2];
                state_d  = ROT2;
                done_d   = 1'b0;
              end
            end
            3'd6: begin
              if (depth_q < CNT_W'(1)) begin
                set_unf = 1'b1;
              end else begin
                wr0_en   = 1'b1;
                wr0_data = op_data;
              end
            end
            3'd7: begin
              if (depth_q < CNT_W'(2)) begin
                set_unf = 1'b1;
              end else begin
                wr0_en   = 1'b1;
                wr0_idx  = idx_m2;
                wr0_data = op_data;
                depth_d  = depth_q - CNT_W'(1);
              end
            end
            default: ;
          endcase
          done_err_d = set_ovf | set_unf;
        end
      end
      ROT2: begin
        wr0_en   = 1'b1;
        wr0_idx  = idx_m3;
        wr0_data = temp_q;
        state_d  = IDLE;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      temp_q     <= '0;
      shift_q    <= '0;
      shout_q    <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      temp_q     <= temp_d;
      shift_q    <= shift_d;
      shout_q    <= shift_q[DATA_W-1];
      done_q     <= done_d;
      done_err_q <= done_err_d;
      ovf_q      <= err_clear ? 1'b0 : (ovf_q | set_ovf);
      unf_q      <= err_clear ? 1'b0 : (unf_q | set_unf);
      rdy_en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_en) mem_q[wr0_idx] <= wr0_data;
      if (wr1_en) mem_q[wr1_idx] <= wr1_data;
    end
  end

endmodule

// File: tb/tb_spell_stack_engine.sv
// tb/tb_spell_stack_engine.sv - directed self-checking bench for spell_stack_engine (DEPTH=4)
module tb_spell_stack_engine;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] op_data;
  logic              done, done_err;
  logic [DATA_W-1:0] top, below;
  logic [CNT_W-1:0]  depth;
  logic              err_overflow, err_underflow, err_clear;
  logic              dbg_shift_in, dbg_shift_out, dbg_load, dbg_dump;

  int n_checks = 0;
  int n_fail   = 0;

  spell_stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
    .done(done), .done_err(done_err), .top(top), .below(below), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clear(err_clear),
    .dbg_shift_in(dbg_shift_in), .dbg_shift_out(dbg_shift_out),
    .dbg_load(dbg_load), .dbg_dump(dbg_dump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] code, input logic [7:0] data, input logic exp_err);
    op_valid = 1'b1;
    op_code  = code;
    op_data  = data;
    tick();
    op_valid = 1'b0;
    chk($sformatf("done op%0d", code), {31'd0, done}, 32'd1);
    chk($sformatf("done_err op%0d", code), {31'd0, done_err}, {31'd0, exp_err});
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovf cleared", {31'd0, err_overflow}, 32'd0);
    chk("unf cleared", {31'd0, err_underflow}, 32'd0);
  endtask

  logic [7:0] pat;

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_data = 8'd0;
    err_clear = 1'b0; dbg_shift_in = 1'b0; dbg_load = 1'b0; dbg_dump = 1'b0;
    #12;
    chk("rst depth", 32'(depth), 32'd0);
    chk("rst top", 32'(top), 32'd0);
    chk("rst below", 32'(below), 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst flags", {30'd0, err_overflow, err_underflow}, 32'd0);
    chk("rst shout", {31'd0, dbg_shift_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("ready before edge", {31'd0, op_ready}, 32'd0);
    tick();
    chk("ready after release", {31'd0, op_ready}, 32'd1);

    // 1: three pushes
    do_op(3'd1, 8'h11, 1'b0);
    do_op(3'd1, 8'h22, 1'b0);
    do_op(3'd1, 8'h33, 1'b0);
    chk("t1 depth", 32'(depth), 32'd3);
    chk("t1 top", 32'(top), 32'h33);
    chk("t1 below", 32'(below), 32'h22);
    do_op(3'd0, 8'h00, 1'b0);
    chk("nop depth", 32'(depth), 32'd3);

    // 2: ROT
    op_valid = 1'b1; op_code = 3'd5;
    tick();
    op_valid = 1'b0;
    chk("rot ready low", {31'd0, op_ready}, 32'd0);
    chk("rot no early done", {31'd0, done}, 32'd0);
    tick();
    chk("rot ready back", {31'd0, op_ready}, 32'd1);
    chk("rot done", {31'd0, done}, 32'd1);
    chk("rot done_err", {31'd0, done_err}, 32'd0);
    chk("rot top", 32'(top), 32'h11);
    chk("rot below", 32'(below), 32'h33);
    tick();
    chk("rot done one cycle", {31'd0, done}, 32'd0);
    do_op(3'd2, 8'h00, 1'b0);
    chk("pop1 top", 32'(top), 32'h33);
    do_op(3'd2, 8'h00, 1'b0);
    chk("entry0", 32'(top), 32'h22);
    do_op(3'd2, 8'h00, 1'b0);
    chk("empty depth", 32'(depth), 32'd0);

    // 4: underflow on empty
    do_op(3'd2, 8'h00, 1'b1);
    chk("unf flag", {31'd0, err_underflow}, 32'd1);
    do_op(3'd7, 8'h05, 1'b1);
    chk("unf depth", 32'(depth), 32'd0);
    chk("unf top", 32'(top), 32'd0);
    clear_errs();

    // DUP / SETTOP / SWAP / REDUCE and SWAP boundary
    do_op(3'd1, 8'h01, 1'b0);
    do_op(3'd4, 8'h00, 1'b1);
    chk("swap d1 depth", 32'(depth), 32'd1);
    do_op(3'd3, 8'h00, 1'b0);
    chk("dup below", 32'(below), 32'h01);
    do_op(3'd6, 8'h02, 1'b0);
    chk("settop", {16'd0, below, top}, 32'h0102);
    do_op(3'd4, 8'h00, 1'b0);
    chk("swap", {16'd0, below, top}, 32'h0201);
    do_op(3'd7, 8'h09, 1'b0);
    chk("reduce depth", 32'(depth), 32'd1);
    chk("reduce top", 32'(top), 32'h09);
    clear_errs();

    // 3: overflow at DEPTH
    do_op(3'd1, 8'hA1, 1'b0);
    do_op(3'd1, 8'hA2, 1'b0);
    do_op(3'd1, 8'hA3, 1'b0);
    chk("full depth", 32'(depth), 32'd4);
    do_op(3'd1, 8'hAA, 1'b1);
    chk("ovf flag", {31'd0, err_overflow}, 32'd1);
    chk("ovf depth", 32'(depth), 32'd4);
    chk("ovf top", 32'(top), 32'hA3);
    clear_errs();
    err_clear = 1'b1;
    do_op(3'd3, 8'h00, 1'b1);
    err_clear = 1'b0;
    chk("clear beats set", {31'd0, err_overflow}, 32'd0);
    do_op(3'd2, 8'h00, 1'b0);

    // 5: debug load/dump
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      dbg_shift_in = pat[i];
      tick();
    end
    dbg_shift_in = 1'b0;
    dbg_load = 1'b1;
    #1;
    chk("ready low on load", {31'd0, op_ready}, 32'd0);
    tick();
    dbg_load = 1'b0;
    chk("load depth", 32'(depth), 32'd4);
    chk("load top", 32'(top), 32'hA5);
    chk("load no done", {31'd0, done}, 32'd0);
    dbg_load = 1'b1;
    tick();
    dbg_load = 1'b0;
    chk("load ovf", {31'd0, err_overflow}, 32'd1);
    chk("load ovf depth", 32'(depth), 32'd4);
    clear_errs();
    dbg_dump = 1'b1;
    tick();
    dbg_dump = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk($sformatf("dump bit%0d", i), {31'd0, dbg_shift_out}, {31'd0, pat[i]});
    end

    // 6: reset mid-ROT
    op_valid = 1'b1; op_code = 3'd5;
    tick();
    op_valid = 1'b0;
    chk("in ROT2", {31'd0, op_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrot depth", 32'(depth), 32'd0);
    chk("midrot top", 32'(top), 32'd0);
    chk("midrot done", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post rst no done", {31'd0, done}, 32'd0);
    chk("post rst ready", {31'd0, op_ready}, 32'd1);
    do_op(3'd1, 8'h77, 1'b0);
    chk("post rst depth", 32'(depth), 32'd1);
    chk("post rst top", 32'(top), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
